// File: rtl/mipi_phy_ser_lane.sv
// mipi_phy_ser_lane
// Single-lane MIPI D-PHY transmit sequencer. It takes a byte stream over a
// valid/ready handshake and produces, every byte-clock cycle, the LP line
// levels, the HS driver enable and the 8-bit word for an external 8:1 DDR
// serializer (bit 0 first). Each burst runs:
//   LP-11 -> LP-01 -> LP-00 -> HS-zero -> 0xB8 -> payload -> trail -> LP-11.
//
// Ports
//   clk        byte clock, rising edge
//   resetb     synchronous active-low reset
//   din        payload byte, bit 0 on the wire first
//   din_valid  din is valid
//   din_last   din is the final byte of the packet
//   din_ready  byte accepted on an edge where din_valid && din_ready
//   lp_p/lp_n  LP driver levels for Dp/Dn
//   hs_oe      HS driver enable
//   hs_data    parallel HS word to the serializer
//   busy       high in every state except ST_STOP
//   underflow  one-cycle pulse when the packet ends without din_last
module mipi_phy_ser_lane #(
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 2,
  parameter int T_HS_ZERO    = 4,
  parameter int T_HS_TRAIL   = 2,
  parameter int T_HS_EXIT    = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       lp_p,
  output logic       lp_n,
  output logic       hs_oe,
  output logic [7:0] hs_data,
  output logic       busy,
  output logic       underflow
);

  typedef enum logic [2:0] {
    ST_STOP, ST_LPX, ST_PREP, ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL, ST_EXIT
  } state_t;

  localparam logic [7:0] SYNC_WORD  = 8'hB8;
  // The shared counter is loaded with duration-1 on entry and the state
  // advances when it reads zero, so each timed state lasts exactly its count.
  localparam logic [7:0] LPX_LOAD   = 8'(T_LPX - 1);
  localparam logic [7:0] PREP_LOAD  = 8'(T_HS_PREPARE - 1);
  localparam logic [7:0] ZERO_LOAD  = 8'(T_HS_ZERO - 1);
  localparam logic [7:0] TRAIL_LOAD = 8'(T_HS_TRAIL - 1);
  localparam logic [7:0] EXIT_LOAD  = 8'(T_HS_EXIT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       last_seen, last_seen_nxt;
  logic [7:0] hs_data_nxt;
  logic       underflow_nxt;
  logic       lp_p_nxt, lp_n_nxt, hs_oe_nxt, busy_nxt;
  logic [7:0] trail_word;

  // Once the last byte has been taken the lane must not accept another one
  // while that byte is still on the wire.
  assign din_ready = ((state == ST_SYNC) || (state == ST_DATA)) && !last_seen && din_valid;

  // Trail drives the complement of the final HS bit (bit 7 is sent last).
  assign trail_word = hs_data[7] ? 8'h00 : 8'hFF;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the case statement can infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    hs_data_nxt   = 8'h00;
    underflow_nxt = 1'b0;
    last_seen_nxt = 1'b0;
    case (state)
      ST_STOP: begin
        // The request byte is only sampled here, not consumed.
        if (din_valid) begin
          state_nxt = ST_LPX;
          cnt_nxt   = LPX_LOAD;
        end
      end
      ST_LPX: begin
        if (cnt == 8'd0) begin
          state_nxt = ST_PREP;
          cnt_nxt   = PREP_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_PREP: begin
        if (cnt == 8'd0) begin
          state_nxt = ST_ZERO;
          cnt_nxt   = ZERO_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_ZERO: begin
        if (cnt == 8'd0) begin
          state_nxt   = ST_SYNC;
          cnt_nxt     = 8'd0;
          hs_data_nxt = SYNC_WORD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (last_seen) begin
          state_nxt   = ST_TRAIL;
          cnt_nxt     = TRAIL_LOAD;
          hs_data_nxt = trail_word;
        end else if (din_valid) begin
          state_nxt     = ST_DATA;
          hs_data_nxt   = din;
          last_seen_nxt = din_last;
        end else begin
          // HS cannot stall: a missing byte ends the packet early.
          state_nxt     = ST_TRAIL;
          cnt_nxt       = TRAIL_LOAD;
          hs_data_nxt   = trail_word;
          underflow_nxt = 1'b1;
        end
      end
      ST_TRAIL: begin
        if (cnt == 8'd0) begin
          state_nxt = ST_EXIT;
          cnt_nxt   = EXIT_LOAD;
        end else begin
          cnt_nxt     = cnt - 8'd1;
          hs_data_nxt = hs_data;
        end
      end
      ST_EXIT: begin
        if (cnt == 8'd0) begin
          state_nxt = ST_STOP;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_STOP;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Line levels are decoded from the next state so they register on the same
  // edge as the state itself.
  always_comb begin
    lp_p_nxt  = 1'b0;
    lp_n_nxt  = 1'b0;
    hs_oe_nxt = 1'b0;
    busy_nxt  = 1'b1;
    case (state_nxt)
      ST_STOP:  begin lp_p_nxt = 1'b1; lp_n_nxt = 1'b1; busy_nxt = 1'b0; end
      ST_LPX:   lp_n_nxt = 1'b1;
      ST_PREP:  ;
      ST_EXIT:  begin lp_p_nxt = 1'b1; lp_n_nxt = 1'b1; end
      default:  hs_oe_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // pre-edge values, independent of statement order.
    if (!resetb) begin
      state     <= ST_STOP;
      cnt       <= 8'd0;
      last_seen <= 1'b0;
      lp_p      <= 1'b1;
      lp_n      <= 1'b1;
      hs_oe     <= 1'b0;
      hs_data   <= 8'h00;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_seen <= last_seen_nxt;
      lp_p      <= lp_p_nxt;
      lp_n      <= lp_n_nxt;
      hs_oe     <= hs_oe_nxt;
      hs_data   <= hs_data_nxt;
      busy      <= busy_nxt;
      underflow <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_mipi_phy_ser_lane.sv
// Self-checking bench for mipi_phy_ser_lane. Two instances: A with default
// timing, B with minimum/mixed timing. Only the selected instance sees
// din_valid, so the other one idles in LP-11.
module tb_mipi_phy_ser_lane;

  typedef struct packed {
    logic       lp_p;
    logic       lp_n;
    logic       hs_oe;
    logic [7:0] hs_data;
    logic       busy;
    logic       underflow;
  } out_t;

  typedef out_t       out_q_t[$];
  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       exp_ready;
    out_t       exp;
  } vec_t;

  localparam int LPX_T[2]   = '{2, 1};
  localparam int PREP_T[2]  = '{2, 3};
  localparam int ZERO_T[2]  = '{4, 1};
  localparam int TRAIL_T[2] = '{2, 1};
  localparam int EXIT_T[2]  = '{2, 3};

  logic       clk;
  logic       resetb;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       sel;

  logic       valid_a, valid_b, ready_a, ready_b;
  logic       lp_p_a, lp_n_a, hs_oe_a, busy_a, uf_a;
  logic       lp_p_b, lp_n_b, hs_oe_b, busy_b, uf_b;
  logic [7:0] hs_data_a, hs_data_b;
  out_t       out_a, out_b, cur;
  logic       cur_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mipi_phy_ser_lane #(
    .T_LPX(LPX_T[0]), .T_HS_PREPARE(PREP_T[0]), .T_HS_ZERO(ZERO_T[0]),
    .T_HS_TRAIL(TRAIL_T[0]), .T_HS_EXIT(EXIT_T[0])
  ) u_dut_a (
    .clk(clk), .resetb(resetb), .din(din), .din_valid(valid_a), .din_last(din_last),
    .din_ready(ready_a), .lp_p(lp_p_a), .lp_n(lp_n_a), .hs_oe(hs_oe_a),
    .hs_data(hs_data_a), .busy(busy_a), .underflow(uf_a)
  );

  mipi_phy_ser_lane #(
    .T_LPX(LPX_T[1]), .T_HS_PREPARE(PREP_T[1]), .T_HS_ZERO(ZERO_T[1]),
    .T_HS_TRAIL(TRAIL_T[1]), .T_HS_EXIT(EXIT_T[1])
  ) u_dut_b (
    .clk(clk), .resetb(resetb), .din(din), .din_valid(valid_b), .din_last(din_last),
    .din_ready(ready_b), .lp_p(lp_p_b), .lp_n(lp_n_b), .hs_oe(hs_oe_b),
    .hs_data(hs_data_b), .busy(busy_b), .underflow(uf_b)
  );

  assign valid_a   = (sel == 1'b0) ? din_valid : 1'b0;
  assign valid_b   = (sel == 1'b1) ? din_valid : 1'b0;
  assign out_a     = {lp_p_a, lp_n_a, hs_oe_a, hs_data_a, busy_a, uf_a};
  assign out_b     = {lp_p_b, lp_n_b, hs_oe_b, hs_data_b, busy_b, uf_b};
  assign cur       = sel ? out_b : out_a;
  assign cur_ready = sel ? ready_b : ready_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic out_t mk(input logic p, input logic n, input logic oe,
                              input logic [7:0] d, input logic b, input logic u);
    out_t o;
    o = {p, n, oe, d, b, u};
    return o;
  endfunction

  function automatic out_t idle_out();
    return mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endfunction

  // Reference: the burst as a list of per-cycle line states, starting with
  // the cycle after din_valid is sampled in LP-11. m = bytes actually sent.
  function automatic void build(input int s, input byte_q_t b, input int m,
                                input bit u, output out_q_t q);
    logic [7:0] lastw, trail;
    q = {};
    for (int i = 0; i < LPX_T[s]; i++)  q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
    for (int i = 0; i < PREP_T[s]; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0));
    for (int i = 0; i < ZERO_T[s]; i++) q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b1, 8'hB8, 1'b1, 1'b0));
    for (int i = 0; i < m; i++)         q.push_back(mk(1'b0, 1'b0, 1'b1, b[i], 1'b1, 1'b0));
    lastw = (m > 0) ? b[m-1] : 8'hB8;
    trail = lastw[7] ? 8'h00 : 8'hFF;
    for (int i = 0; i < TRAIL_T[s]; i++)
      q.push_back(mk(1'b0, 1'b0, 1'b1, trail, 1'b1, u && (i == 0)));
    for (int i = 0; i < EXIT_T[s]; i++) q.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
  endfunction

  // Drives one packet from idle. With u set the source stalls after k bytes;
  // with resume it then re-asserts valid through trail/exit, which must be
  // ignored. Ends at posedge+1 with the lane back in LP-11.
  task automatic run_packet(input string tag, input int s, input byte_q_t b,
                            input int k, input bit u, input bit resume);
    out_q_t exp;
    out_t   want;
    int     m, idx, fires, pre, stall, busy_cnt;
    bit     fire;
    m = u ? k : b.size();
    build(s, b, m, u, exp);
    sel      = (s != 0);
    idx      = 0;
    fires    = 0;
    busy_cnt = 0;
    pre      = LPX_T[s] + PREP_T[s] + ZERO_T[s] + 1;
    stall    = pre + m;
    for (int c = 0; c <= exp.size(); c++) begin
      if (c < pre || idx < m) begin
        din_valid = 1'b1;
        din       = b[(idx < b.size()) ? idx : 0];
        din_last  = !u && (idx == b.size() - 1);
      end else if (resume && c > stall && c < exp.size()) begin
        din_valid = 1'b1;
        din       = 8'hEE;
        din_last  = 1'b0;
      end else begin
        din_valid = 1'b0;
        din       = 8'h00;
        din_last  = 1'b0;
      end
      #1;
      fire = din_valid && cur_ready;
      @(posedge clk);
      #1;
      if (fire) begin idx++; fires++; end
      if (cur.busy) busy_cnt++;
      want = (c < exp.size()) ? exp[c] : idle_out();
      check($sformatf("%s cyc%0d outputs", tag, c), 32'(cur), 32'(want));
    end
    din_valid = 1'b0;
    check($sformatf("%s bytes accepted", tag), 32'(fires), 32'(m));
    check($sformatf("%s burst length", tag), 32'(busy_cnt),
          32'(LPX_T[s] + PREP_T[s] + ZERO_T[s] + 1 + m + TRAIL_T[s] + EXIT_T[s]));
  endtask

  vec_t    vecs[17];
  byte_q_t bq;
  out_q_t  eq;
  out_t    want;

  initial begin
    resetb = 1'b0; din = 8'h00; din_valid = 1'b1; din_last = 1'b0; sel = 1'b0;

    // Reset state, with din_valid held high to show it is not acted on.
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs A", 32'(out_a), 32'(idle_out()));
    check("reset outputs B", 32'(out_b), 32'(idle_out()));
    check("reset ready A", 32'(ready_a), 32'd0);
    din_valid = 1'b0;
    resetb    = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", 32'(out_a), 32'(idle_out()));

    // Table: 0x11, 0x22, 0xA5(last), valid held until the last is taken.
    for (int r = 0; r < 17; r++) begin
      vecs[r].valid     = (r <= 11);
      vecs[r].data      = (r <= 9) ? 8'h11 : (r == 10) ? 8'h22 : (r == 11) ? 8'hA5 : 8'h00;
      vecs[r].last      = (r == 11);
      vecs[r].exp_ready = (r >= 9 && r <= 11);
      if (r < 2)        vecs[r].exp = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      else if (r < 4)   vecs[r].exp = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      else if (r < 8)   vecs[r].exp = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      else if (r == 8)  vecs[r].exp = mk(1'b0, 1'b0, 1'b1, 8'hB8, 1'b1, 1'b0);
      else if (r < 12)  vecs[r].exp = mk(1'b0, 1'b0, 1'b1, vecs[r].data, 1'b1, 1'b0);
      else if (r < 14)  vecs[r].exp = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      else if (r < 16)  vecs[r].exp = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      else              vecs[r].exp = idle_out();
    end
    sel = 1'b0;
    for (int r = 0; r < 17; r++) begin
      din_valid = vecs[r].valid; din = vecs[r].data; din_last = vecs[r].last;
      #1;
      check($sformatf("table row%0d ready", r), 32'(ready_a), 32'(vecs[r].exp_ready));
      @(posedge clk); #1;
      check($sformatf("table row%0d outputs", r), 32'(out_a), 32'(vecs[r].exp));
    end
    din_valid = 1'b0;

    // Single byte with last: B8,7F,FF,FF and exactly one accept.
    bq = {8'h7F};
    run_packet("single", 0, bq, 1, 1'b0, 1'b0);
    // Underflow after two bytes; late bytes during trail/exit are ignored.
    bq = {8'h01, 8'h02, 8'h03};
    run_packet("underflow", 0, bq, 2, 1'b1, 1'b1);
    // Underflow right at the sync word: trail follows 0xB8, so 0x00.
    bq = {8'h55};
    run_packet("uf at sync", 0, bq, 0, 1'b1, 1'b0);

    // Reset while the second payload byte is on the wire.
    for (int c = 0; c <= 10; c++) begin
      din_valid = 1'b1; din = (c <= 9) ? 8'h11 : 8'h22; din_last = 1'b0;
      @(posedge clk); #1;
    end
    check("mid-burst second byte", 32'(out_a.hs_data), 32'h22);
    resetb = 1'b0; din = 8'h33;
    @(posedge clk); #1;
    check("mid-burst reset outputs", 32'(out_a), 32'(idle_out()));
    check("mid-burst reset ready", 32'(ready_a), 32'd0);
    resetb = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    check("post-reset idle", 32'(out_a), 32'(idle_out()));
    bq = {8'hC3, 8'h3C};
    run_packet("after reset", 0, bq, 2, 1'b0, 1'b0);

    // Valid held across two single-byte packets: one LP-11 cycle between them.
    bq = {8'h3C};
    build(0, bq, 1, 1'b0, eq);
    for (int c = 0; c < 2 * eq.size() + 3; c++) begin
      din_valid = (c <= 2 * eq.size() + 1); din = 8'h3C; din_last = 1'b1;
      @(posedge clk); #1;
      if (c < eq.size())           want = eq[c];
      else if (c == eq.size())     want = idle_out();
      else if (c <= 2 * eq.size()) want = eq[c - eq.size() - 1];
      else                         want = idle_out();
      check($sformatf("b2b cyc%0d outputs", c), 32'(out_a), 32'(want));
    end
    din_valid = 1'b0; din_last = 1'b0;

    // Minimum-duration instance.
    bq = {8'h80, 8'h00};
    run_packet("min", 1, bq, 2, 1'b0, 1'b0);
    bq = {8'h9A, 8'h10};
    run_packet("min uf", 1, bq, 1, 1'b1, 1'b1);

    // Randomized packets on both instances.
    for (int p = 0; p < 40; p++) begin
      int n, k, s;
      bit u, rs;
      s  = int'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 6));
      u  = ($urandom_range(0, 3) == 0);
      k  = int'($urandom_range(0, n - 1));
      rs = u && ($urandom_range(0, 1) == 1);
      bq = {};
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      run_packet($sformatf("rand%0d", p), s, bq, k, u, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
